// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register pair and its multiply-accumulate engine.
package hilo_pkg;

   localparam logic [1:0] ACC_MADDU = 2'b00;
   localparam logic [1:0] ACC_MADD  = 2'b01;
   localparam logic [1:0] ACC_MSUBU = 2'b10;
   localparam logic [1:0] ACC_MSUB  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2
   } state_e;

   function automatic logic is_signed(input logic [1:0] op);
      return (op == ACC_MADD) || (op == ACC_MSUB);
   endfunction

   function automatic logic is_sub(input logic [1:0] op);
      return (op == ACC_MSUBU) || (op == ACC_MSUB);
   endfunction

endpackage

// File: rtl/hilo_mul.sv
// Registered DW x DW -> 2DW multiplier, signed or unsigned, result modulo 2^(2DW).
module hilo_mul #(
   parameter int unsigned DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            sgn,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [2*DW-1:0] p
);

   logic [2*DW-1:0] ax;
   logic [2*DW-1:0] bx;

   // Extending both operands to 2DW first gives the correct low 2DW bits for either signedness.
   always_comb begin
      ax = sgn ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
      bx = sgn ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p <= '0;
      end else if (en) begin
         p <= ax * bx;
      end
   end

endmodule

// File: rtl/hilo_acc.sv
// HI/LO register pair with per-half writes, forwarding view and a two-stage
// multiply-accumulate engine (IDLE -> MUL -> ACC).
module hilo_acc #(
   parameter int unsigned DW     = 32,
   parameter bit          BYPASS = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_hi,
   input  logic          we_lo,
   input  logic [DW-1:0] hi_i,
   input  logic [DW-1:0] lo_i,
   input  logic          acc_req,
   input  logic [1:0]    acc_op,
   input  logic [DW-1:0] acc_a,
   input  logic [DW-1:0] acc_b,
   output logic          acc_busy,
   output logic          acc_done,
   output logic [DW-1:0] hi_o,
   output logic [DW-1:0] lo_o,
   output logic [DW-1:0] hi_fwd_o,
   output logic [DW-1:0] lo_fwd_o
);
   import hilo_pkg::*;

   state_e          state;
   state_e          state_n;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   b_q;
   logic [1:0]      op_q;
   logic [2*DW-1:0] prod;
   logic [2*DW-1:0] cur;
   logic [2*DW-1:0] sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      acc_busy = (state != IDLE);
      case (state)
         IDLE:    if (acc_req) state_n = MUL;
         MUL:     state_n = ACC;
         ACC:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= '0;
      end else if (state == IDLE && acc_req) begin
         a_q  <= acc_a;
         b_q  <= acc_b;
         op_q <= acc_op;
      end
   end

   hilo_mul #(
      .DW(DW)
   ) u_mul (
      .clk (clk),
      .rst (rst),
      .en  (state == MUL),
      .sgn (is_signed(op_q)),
      .a   (a_q),
      .b   (b_q),
      .p   (prod)
   );

   always_comb begin
      cur = {hi_o, lo_o};
      sum = is_sub(op_q) ? (cur - prod) : (cur + prod);
   end

   // The commit owns both halves in ACC; direct writes are only honoured elsewhere.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_o     <= '0;
         lo_o     <= '0;
         acc_done <= 1'b0;
      end else begin
         acc_done <= (state == ACC);
         if (state == ACC) begin
            {hi_o, lo_o} <= sum;
         end else begin
            if (we_hi) hi_o <= hi_i;
            if (we_lo) lo_o <= lo_i;
         end
      end
   end

   always_comb begin
      hi_fwd_o = hi_o;
      lo_fwd_o = lo_o;
      if (BYPASS) begin
         if (state == ACC) begin
            {hi_fwd_o, lo_fwd_o} = sum;
         end else begin
            if (we_hi) hi_fwd_o = hi_i;
            if (we_lo) lo_fwd_o = lo_i;
         end
      end
   end

endmodule

// File: tb/tb_hilo_acc.sv
// Randomised bench for hilo_acc against a transaction-level 64-bit reference model.
module tb_hilo_acc;

   logic        clk = 1'b0;
   logic        rst, we_hi, we_lo, acc_req;
   logic [1:0]  acc_op;
   logic [31:0] hi_i, lo_i, acc_a, acc_b;
   logic        acc_busy, acc_done;
   logic [31:0] hi_o, lo_o, hi_fwd_o, lo_fwd_o;

   int errors = 0;
   int checks = 0;
   logic [63:0] m;

   hilo_acc #(
      .DW(32),
      .BYPASS(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .we_hi(we_hi), .we_lo(we_lo), .hi_i(hi_i), .lo_i(lo_i),
      .acc_req(acc_req), .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b),
      .acc_busy(acc_busy), .acc_done(acc_done), .hi_o(hi_o), .lo_o(lo_o),
      .hi_fwd_o(hi_fwd_o), .lo_fwd_o(lo_fwd_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] ref_result(input logic [63:0] base, input logic [1:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      if (op == 2'b01 || op == 2'b11) p = 64'(sa * sb);
      else                            p = {32'b0, a} * {32'b0, b};
      return (op == 2'b10 || op == 2'b11) ? base - p : base + p;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_regs(input logic [63:0] v);
      we_hi = 1'b1; we_lo = 1'b1; hi_i = v[63:32]; lo_i = v[31:0];
      tick();
      we_hi = 1'b0; we_lo = 1'b0;
      m = v;
   endtask

   // Drives one accumulate from the current IDLE cycle, optionally with direct writes
   // at the request edge (w0), during MUL (wm) and during ACC (wa), and a stray
   // request during MUL. Masks are {hi,lo}. Leaves the bench in the acc_done cycle.
   task automatic do_acc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] w0, input logic [1:0] wm, input logic [1:0] wa,
                         input logic reqm);
      logic [63:0] exp_v;
      acc_req = 1'b1; acc_op = op; acc_a = a; acc_b = b;
      we_hi = w0[1]; we_lo = w0[0]; hi_i = $urandom; lo_i = $urandom;
      if (w0[1]) m[63:32] = hi_i;
      if (w0[0]) m[31:0]  = lo_i;
      tick();
      acc_req = reqm; acc_op = 2'($urandom); acc_a = $urandom; acc_b = $urandom;
      we_hi = wm[1]; we_lo = wm[0]; hi_i = $urandom; lo_i = $urandom;
      if (wm[1]) m[63:32] = hi_i;
      if (wm[0]) m[31:0]  = lo_i;
      checks++;
      if (acc_busy !== 1'b1 || acc_done !== 1'b0) begin
         errors++;
         $display("FAIL acc_mul_flags: busy=%b done=%b, expected busy=1 done=0", acc_busy, acc_done);
      end
      tick();
      acc_req = 1'b0;
      we_hi = 1'b0; we_lo = 1'b0;
      exp_v = ref_result(m, op, a, b);
      checks++;
      if (acc_busy !== 1'b1 || acc_done !== 1'b0) begin
         errors++;
         $display("FAIL acc_acc_flags: busy=%b done=%b, expected busy=1 done=0", acc_busy, acc_done);
      end
      we_hi = wa[1]; we_lo = wa[0]; hi_i = $urandom; lo_i = 32'h0000AAAA;
      #1;
      checks++;
      if ({hi_fwd_o, lo_fwd_o} !== exp_v) begin
         errors++;
         $display("FAIL acc_fwd: got %h_%h, expected %h", hi_fwd_o, lo_fwd_o, exp_v);
      end
      tick();
      we_hi = 1'b0; we_lo = 1'b0;
      checks++;
      if (acc_busy !== 1'b0 || acc_done !== 1'b1) begin
         errors++;
         $display("FAIL acc_done_flags: busy=%b done=%b, expected busy=0 done=1", acc_busy, acc_done);
      end
      checks++;
      if ({hi_o, lo_o} !== exp_v) begin
         errors++;
         $display("FAIL acc_result op=%0d a=%h b=%h: got %h_%h, expected %h", op, a, b, hi_o, lo_o, exp_v);
      end
      m = exp_v;
   endtask

   task automatic test_reset;
      rst = 1'b1; we_hi = 1'b1; we_lo = 1'b1; hi_i = '1; lo_i = '1;
      acc_req = 1'b0; acc_op = '0; acc_a = '0; acc_b = '0;
      tick();
      rst = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
      m = '0;
      checks++;
      if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_regs: got %h_%h, expected 0_0", hi_o, lo_o);
      end
      checks++;
      if (acc_busy !== 1'b0 || acc_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: busy=%b done=%b, expected 0 0", acc_busy, acc_done);
      end
   endtask

   task automatic test_write_fwd;
      logic [31:0] eh, el;
      we_hi = 1'b1; hi_i = 32'h12345678; we_lo = 1'b0; lo_i = 32'hFFFFFFFF;
      #1;
      checks++;
      if (hi_fwd_o !== 32'h12345678 || lo_fwd_o !== 32'h0) begin
         errors++;
         $display("FAIL fwd_same_cycle: got %h_%h, expected 12345678_00000000", hi_fwd_o, lo_fwd_o);
      end
      tick();
      we_hi = 1'b0;
      m = {32'h12345678, 32'h0};
      checks++;
      if (hi_o !== 32'h12345678 || lo_o !== 32'h0) begin
         errors++;
         $display("FAIL write_hi_only: got %h_%h, expected 12345678_00000000", hi_o, lo_o);
      end
      for (int i = 0; i < 8; i++) begin
         we_hi = 1'($urandom_range(0, 1)); we_lo = 1'($urandom_range(0, 1));
         hi_i = $urandom; lo_i = $urandom;
         #1;
         eh = we_hi ? hi_i : m[63:32];
         el = we_lo ? lo_i : m[31:0];
         checks++;
         if (hi_fwd_o !== eh || lo_fwd_o !== el) begin
            errors++;
            $display("FAIL fwd_rand[%0d]: got %h_%h, expected %h_%h", i, hi_fwd_o, lo_fwd_o, eh, el);
         end
         m = {eh, el};
         tick();
         we_hi = 1'b0; we_lo = 1'b0;
         checks++;
         if ({hi_o, lo_o} !== m) begin
            errors++;
            $display("FAIL write_rand[%0d]: got %h_%h, expected %h", i, hi_o, lo_o, m);
         end
      end
   endtask

   task automatic test_maddu;
      set_regs(64'h0);
      do_acc(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 2'b00, 2'b00, 1'b0);
      checks++;
      if ({hi_o, lo_o} !== 64'hFFFFFFFE_00000001) begin
         errors++;
         $display("FAIL maddu_fixed: got %h_%h, expected fffffffe_00000001", hi_o, lo_o);
      end
   endtask

   task automatic test_msub;
      set_regs(64'h0);
      do_acc(2'b11, 32'hFFFFFFFF, 32'h00000002, 2'b00, 2'b00, 2'b00, 1'b0);
      checks++;
      if ({hi_o, lo_o} !== 64'h00000000_00000002) begin
         errors++;
         $display("FAIL msub_fixed: got %h_%h, expected 00000000_00000002", hi_o, lo_o);
      end
   endtask

   task automatic test_random_acc;
      for (int i = 0; i < 12; i++) begin
         set_regs({$urandom, $urandom});
         do_acc(2'($urandom), $urandom, $urandom, 2'($urandom), 2'($urandom), 2'($urandom),
                1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_conflicts;
      set_regs(64'h0);
      do_acc(2'b00, 32'd3, 32'd4, 2'b00, 2'b00, 2'b01, 1'b1);
      checks++;
      if (lo_o !== 32'h0000000C || hi_o !== 32'h0) begin
         errors++;
         $display("FAIL conflict_result: got %h_%h, expected 00000000_0000000c", hi_o, lo_o);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (acc_done !== 1'b0 || acc_busy !== 1'b0 || {hi_o, lo_o} !== m) begin
            errors++;
            $display("FAIL conflict_extra[%0d]: done=%b busy=%b regs=%h_%h, expected 0 0 %h",
                     i, acc_done, acc_busy, hi_o, lo_o, m);
         end
      end
   endtask

   task automatic test_back_to_back;
      set_regs({$urandom, $urandom});
      do_acc(2'b01, $urandom, $urandom, 2'b00, 2'b00, 2'b00, 1'b0);
      do_acc(2'b10, $urandom, $urandom, 2'b00, 2'b00, 2'b00, 1'b0);
      do_acc(2'b00, $urandom, $urandom, 2'b11, 2'b10, 2'b00, 1'b0);
      tick();
      checks++;
      if (acc_done !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse_width: done=%b, expected 0", acc_done);
      end
   endtask

   task automatic test_abort(input int phase);
      set_regs({$urandom | 32'h1, $urandom | 32'h1});
      acc_req = 1'b1; acc_op = 2'b00; acc_a = 32'd5; acc_b = 32'd5;
      tick();
      acc_req = 1'b0;
      if (phase == 1) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m = '0;
      checks++;
      if (acc_busy !== 1'b0 || acc_done !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
         errors++;
         $display("FAIL abort%0d_state: busy=%b done=%b regs=%h_%h, expected 0 0 0_0",
                  phase, acc_busy, acc_done, hi_o, lo_o);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (acc_done !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            errors++;
            $display("FAIL abort%0d_later[%0d]: done=%b regs=%h_%h, expected 0 0_0",
                     phase, i, acc_done, hi_o, lo_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_fwd();
      test_maddu();
      test_msub();
      test_random_acc();
      test_conflicts();
      test_back_to_back();
      test_abort(0);
      test_abort(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
